ofdm_rx_bit_packer: RTL and testbench

OFDM_RX_BIT_PACKER -- requirements
Module: ofdm_rx_bit_packer

---
 rtl/ofdm_rx_bit_packer.sv | 120 ++++++++++++
 tb/tb_ofdm_rx_bit_packer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_rx_bit_packer.sv
// ofdm_rx_bit_packer: demaps BPSK/QPSK/16-QAM symbols to hard bits and packs them MSB first into words behind a small FIFO
module ofdm_rx_bit_packer #(
    parameter int sample_bit_width_g = 6,
    parameter int carriers_g = 48,
    parameter int out_width_g = 8,
    parameter int fifo_depth_g = 4
) (
    input  logic                                  sys_clk,
    input  logic                                  sys_init,
    input  logic [1:0]                            mode,
    input  logic [sample_bit_width_g-2:0]         qam16_level,
    input  logic signed [sample_bit_width_g-1:0]  mod_i,
    input  logic signed [sample_bit_width_g-1:0]  mod_q,
    input  logic                                  mod_valid,
    output logic                                  mod_ready,
    output logic [out_width_g-1:0]                out_data,
    output logic [$clog2(out_width_g):0]          out_nbits,
    output logic                                  out_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [15:0]                           sym_cnt,
    output logic                                  mode_err
);
    localparam int W = sample_bit_width_g;
    localparam int OW = out_width_g;
    localparam int NW = $clog2(out_width_g) + 1;
    localparam int CW = carriers_g > 1 ? $clog2(carriers_g) : 1;
    localparam int AW = $clog2(fifo_depth_g);
    localparam int FW = AW + 1;

    // Saturating magnitude: the most negative sample maps to the largest positive value
    function automatic logic [W-2:0] mag(input logic [W-1:0] x);
        logic [W-1:0] n;
        n = -x;
        return !x[W-1] ? x[W-2:0] : (n[W-1] ? {(W-1){1'b1}} : n[W-2:0]);
    endfunction

    logic [CW-1:0] cnt;
    logic [1:0]    lmode;
    logic [1:0]    em;
    logic [OW-1:0] acc;
    logic [OW-1:0] acc_sh;
    logic [OW-1:0] w_data;
    logic [NW-1:0] nb;
    logic [NW-1:0] nb_sum;
    logic [NW-1:0] k;
    logic [3:0]    bits;
    logic          accept;
    logic          pop;
    logic          push;
    logic          wrap;
    logic          lo_i;
    logic          lo_q;
    logic [OW-1:0] mem_data [fifo_depth_g];
    logic [NW-1:0] mem_nbits [fifo_depth_g];
    logic          mem_last [fifo_depth_g];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [FW-1:0] count;

    assign mod_ready = count < FW'(fifo_depth_g);
    assign out_valid = count != '0;
    assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
    assign out_nbits = out_valid ? mem_nbits[rd_ptr] : '0;
    assign out_last  = out_valid && mem_last[rd_ptr];

    // Demap the current symbol and work out the packer's next state; the first carrier uses the live mode
    always_comb begin
        accept = mod_valid && mod_ready;
        pop    = out_valid && out_ready;
        em     = (cnt == '0) ? mode : lmode;
        lo_i   = mag(mod_i) < qam16_level;
        lo_q   = mag(mod_q) < qam16_level;
        bits   = em == 2'd0 ? {3'b000, mod_i[W-1]} :
                 em == 2'd2 ? {mod_i[W-1], lo_i, mod_q[W-1], lo_q} :
                              {2'b00, mod_i[W-1], mod_q[W-1]};
        k      = em == 2'd0 ? NW'(1) : em == 2'd2 ? NW'(4) : NW'(2);
        acc_sh = (acc << k) | OW'(bits);
        nb_sum = nb + k;
        wrap   = cnt == CW'(carriers_g - 1);
        push   = accept && (wrap || nb_sum == NW'(OW));
        w_data = acc_sh << (NW'(OW) - nb_sum);
    end

    // Packer, carrier counter, mode latch, status and FIFO pointers
    always_ff @(posedge sys_clk) begin
        if (sys_init) begin
            cnt      <= '0;
            lmode    <= 2'd1;
            acc      <= '0;
            nb       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            sym_cnt  <= '0;
            mode_err <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
                acc <= push ? '0 : acc_sh;
                nb  <= push ? '0 : nb_sum;
                if (cnt == '0) lmode <= mode;
                if (cnt == '0 && mode == 2'd3) mode_err <= 1'b1;
                if (wrap) sym_cnt <= sym_cnt + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + FW'(push) - FW'(pop);
        end
    end

    // FIFO storage; a slot is only read once its push has been counted
    always_ff @(posedge sys_clk) begin
        if (push && !sys_init) begin
            mem_data[wr_ptr]  <= w_data;
            mem_nbits[wr_ptr] <= nb_sum;
            mem_last[wr_ptr]  <= wrap;
        end
    end
endmodule

// File: tb/tb_ofdm_rx_bit_packer.sv
// tb_ofdm_rx_bit_packer: directed scenarios with hand-computed words for the OFDM bit packer
module tb_ofdm_rx_bit_packer;
    logic        sys_clk = 1'b0;
    logic        sys_init = 1'b0;
    logic [1:0]  mode = 2'd1;
    logic [4:0]  qam16_level = 5'd8;
    logic [5:0]  mod_i = '0;
    logic [5:0]  mod_q = '0;
    logic        mod_valid = 1'b0;
    logic        mod_ready;
    logic [7:0]  out_data;
    logic [3:0]  out_nbits;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sym_cnt;
    logic        mode_err;
    int checks = 0;
    int passed = 0;

    typedef struct packed {logic [7:0] d; logic [3:0] n; logic l;} word_t;
    word_t got[$];

    ofdm_rx_bit_packer #(
        .sample_bit_width_g(6),
        .carriers_g(4),
        .out_width_g(8),
        .fifo_depth_g(4)
    ) dut (
        .sys_clk(sys_clk),
        .sys_init(sys_init),
        .mode(mode),
        .qam16_level(qam16_level),
        .mod_i(mod_i),
        .mod_q(mod_q),
        .mod_valid(mod_valid),
        .mod_ready(mod_ready),
        .out_data(out_data),
        .out_nbits(out_nbits),
        .out_last(out_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sym_cnt(sym_cnt),
        .mode_err(mode_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Record every word that is handed over to the consumer
    always @(negedge sys_clk) begin
        if (!sys_init && out_valid && out_ready) got.push_back({out_data, out_nbits, out_last});
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic do_reset;
        sys_init = 1'b1;
        mod_valid = 1'b0;
        step(2);
        sys_init = 1'b0;
        got.delete();
    endtask

    task automatic send(input logic [1:0] m, input int i, input int q);
        int t = 0;
        mode = m;
        mod_i = 6'(i);
        mod_q = 6'(q);
        mod_valid = 1'b1;
        while (!mod_ready && t < 100) begin
            step(1);
            t++;
        end
        if (!mod_ready) begin
            checks++;
            $display("FAIL send_timeout: mod_ready still 0 after %0d cycles", t);
        end else begin
            step(1);
        end
        mod_valid = 1'b0;
    endtask

    task automatic send_qpsk_word(input logic [7:0] w);
        for (int c = 0; c < 4; c++) send(2'd1, w[7-2*c] ? -5 : 5, w[6-2*c] ? -5 : 5);
    endtask

    task automatic wait_words(input int n);
        int t = 0;
        while (got.size() < n && t < 200) begin
            step(1);
            t++;
        end
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
        checks++; if ({out_data, out_nbits, out_last} !== 13'd0) $display("FAIL reset_out_word: got %h/%0d/%b expected 0", out_data, out_nbits, out_last); else passed++;
        checks++; if (sym_cnt !== 16'd0) $display("FAIL reset_sym_cnt: got %0d expected 0", sym_cnt); else passed++;
        checks++; if (mode_err !== 1'b0) $display("FAIL reset_mode_err: got %b expected 0", mode_err); else passed++;
        checks++; if (mod_ready !== 1'b1) $display("FAIL reset_mod_ready: got %b expected 1", mod_ready); else passed++;
    endtask

    task automatic test_qpsk;
        do_reset();
        out_ready = 1'b1;
        send(2'd1, 5, 5);
        send(2'd1, -5, 5);
        send(2'd1, 5, -5);
        checks++; if (out_valid !== 1'b0) $display("FAIL qpsk_early_valid: got %b expected 0", out_valid); else passed++;
        send(2'd1, -5, -5);
        checks++; if (out_valid !== 1'b1) $display("FAIL qpsk_latency: got %b expected 1", out_valid); else passed++;
        checks++; if (out_data !== 8'h27) $display("FAIL qpsk_data: got %h expected 27", out_data); else passed++;
        checks++; if (out_nbits !== 4'd8) $display("FAIL qpsk_nbits: got %0d expected 8", out_nbits); else passed++;
        checks++; if (out_last !== 1'b1) $display("FAIL qpsk_last: got %b expected 1", out_last); else passed++;
        checks++; if (sym_cnt !== 16'd1) $display("FAIL qpsk_sym_cnt: got %0d expected 1", sym_cnt); else passed++;
        step(3);
        checks++; if (got.size() != 1) $display("FAIL qpsk_word_count: got %0d expected 1", got.size()); else passed++;
    endtask

    task automatic test_bpsk;
        do_reset();
        send(2'd0, -3, 0);
        send(2'd0, 3, 0);
        send(2'd0, -3, 0);
        send(2'd0, -3, 0);
        checks++; if ({out_valid, out_data, out_nbits, out_last} !== {1'b1, 8'hB0, 4'd4, 1'b1}) $display("FAIL bpsk_word: got v=%b %h/%0d/%b expected 1 b0/4/1", out_valid, out_data, out_nbits, out_last); else passed++;
        step(3);
        checks++; if (got.size() != 1) $display("FAIL bpsk_word_count: got %0d expected 1", got.size()); else passed++;
    endtask

    task automatic test_qam16;
        word_t exp [2] = '{{8'h96, 4'd8, 1'b0}, {8'h95, 4'd8, 1'b1}};
        do_reset();
        qam16_level = 5'd8;
        send(2'd2, -12, 3);
        send(2'd2, 3, -20);
        send(2'd2, -32, 0);
        send(2'd2, 0, 0);
        wait_words(2);
        step(3);
        checks++; if (got.size() != 2) $display("FAIL qam16_word_count: got %0d expected 2", got.size()); else passed++;
        for (int j = 0; j < 2; j++) begin
            checks++;
            if (j >= got.size() || got[j] !== exp[j]) $display("FAIL qam16_word%0d: got %h expected %h", j, (j < got.size()) ? got[j] : '0, exp[j]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w [5] = '{8'h1B, 8'hE4, 8'h00, 8'hFF, 8'h5A};
        do_reset();
        out_ready = 1'b0;
        for (int s = 0; s < 4; s++) send_qpsk_word(w[s]);
        checks++; if (mod_ready !== 1'b0) $display("FAIL bp_mod_ready_full: got %b expected 0", mod_ready); else passed++;
        mode = 2'd1;
        mod_i = 6'd5;
        mod_q = 6'd5;
        mod_valid = 1'b1;
        step(3);
        mod_valid = 1'b0;
        checks++; if ({out_valid, out_data} !== {1'b1, 8'h1B}) $display("FAIL bp_hold: got v=%b %h expected 1 1b", out_valid, out_data); else passed++;
        checks++; if (sym_cnt !== 16'd4) $display("FAIL bp_sym_cnt_stall: got %0d expected 4", sym_cnt); else passed++;
        out_ready = 1'b1;
        wait_words(4);
        send_qpsk_word(w[4]);
        wait_words(5);
        step(3);
        checks++; if (got.size() != 5) $display("FAIL bp_word_count: got %0d expected 5", got.size()); else passed++;
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (j >= got.size() || got[j] !== {w[j], 4'd8, 1'b1}) $display("FAIL bp_word%0d: got %h expected %h", j, (j < got.size()) ? got[j] : '0, {w[j], 4'd8, 1'b1});
            else passed++;
        end
    endtask

    task automatic test_mode_latch;
        word_t exp [4] = '{{8'h9C, 4'd8, 1'b1}, {8'h96, 4'd8, 1'b0}, {8'h95, 4'd8, 1'b1}, {8'h9C, 4'd8, 1'b1}};
        do_reset();
        out_ready = 1'b1;
        qam16_level = 5'd8;
        send(2'd1, -5, 5);
        send(2'd1, 5, -5);
        send(2'd2, -5, -5);
        send(2'd2, 5, 5);
        send(2'd2, -12, 3);
        send(2'd2, 3, -20);
        send(2'd1, -32, 0);
        send(2'd1, 0, 0);
        checks++; if (mode_err !== 1'b0) $display("FAIL mode_err_early: got %b expected 0", mode_err); else passed++;
        send(2'd3, -5, 5);
        checks++; if (mode_err !== 1'b1) $display("FAIL mode_err_set: got %b expected 1", mode_err); else passed++;
        send(2'd0, 5, -5);
        send(2'd0, -5, -5);
        send(2'd0, 5, 5);
        wait_words(4);
        step(3);
        checks++; if (got.size() != 4) $display("FAIL mode_word_count: got %0d expected 4", got.size()); else passed++;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (j >= got.size() || got[j] !== exp[j]) $display("FAIL mode_word%0d: got %h expected %h", j, (j < got.size()) ? got[j] : '0, exp[j]);
            else passed++;
        end
        checks++; if ({sym_cnt, mode_err} !== {16'd3, 1'b1}) $display("FAIL mode_end_state: got %0d/%b expected 3/1", sym_cnt, mode_err); else passed++;
    endtask

    task automatic test_reset_mid;
        do_reset();
        out_ready = 1'b0;
        send_qpsk_word(8'h27);
        send(2'd1, -5, -5);
        send(2'd1, -5, -5);
        checks++; if ({out_valid, sym_cnt} !== {1'b1, 16'd1}) $display("FAIL mid_pre_state: got v=%b cnt=%0d expected 1/1", out_valid, sym_cnt); else passed++;
        sys_init = 1'b1;
        mod_valid = 1'b1;
        step(1);
        sys_init = 1'b0;
        mod_valid = 1'b0;
        got.delete();
        checks++; if ({out_valid, sym_cnt, mod_ready} !== {1'b0, 16'd0, 1'b1}) $display("FAIL mid_post_reset: got v=%b cnt=%0d rdy=%b expected 0/0/1", out_valid, sym_cnt, mod_ready); else passed++;
        out_ready = 1'b1;
        send_qpsk_word(8'hC3);
        wait_words(1);
        step(3);
        checks++; if (got.size() != 1) $display("FAIL mid_word_count: got %0d expected 1", got.size()); else passed++;
        checks++; if (got.size() < 1 || got[0] !== {8'hC3, 4'd8, 1'b1}) $display("FAIL mid_word: got %h expected %h", (got.size() > 0) ? got[0] : '0, {8'hC3, 4'd8, 1'b1}); else passed++;
        checks++; if (sym_cnt !== 16'd1) $display("FAIL mid_sym_cnt: got %0d expected 1", sym_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_qpsk();
        test_bpsk();
        test_qam16();
        test_back_to_back();
        test_mode_latch();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
